// File: rtl/cn_min_update.sv
// Check-node update stage: folds one row of serial v2c messages into
// {min0, min1, idx0, sign_tot} and emits per-message signs.
module cn_min_update #(
    parameter int MSG_WIDTH   = 6,
    parameter int COL_CNT_WID = 7
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_v2c_vld,
    input  logic [MSG_WIDTH-1:0]   i_v2c,
    input  logic [COL_CNT_WID-1:0] i_col_cnt,
    input  logic                   i_row_start,
    input  logic                   i_row_end,
    output logic                   o_v2c_sign,
    output logic                   o_v2c_sign_vld,
    output logic [MSG_WIDTH-2:0]   o_v2c_abs_0,
    output logic [MSG_WIDTH-2:0]   o_v2c_abs_1,
    output logic [COL_CNT_WID-1:0] o_idx_0,
    output logic                   o_v2c_sign_tot,
    output logic                   o_rslt_vld,
    output logic                   o_busy,
    output logic                   o_seq_err
);
    localparam int MAG_W = MSG_WIDTH - 1;
    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    typedef enum logic {IDLE, ACC} state_t;

    state_t                 state_q, state_d;
    logic [MAG_W-1:0]       min0_q, min0_d, min1_q, min1_d;
    logic [COL_CNT_WID-1:0] idx0_q, idx0_d;
    logic                   sacc_q, sacc_d;
    logic                   seq_err_q, seq_err_d;
    logic [MAG_W-1:0]       abs0_q, abs1_q;
    logic [COL_CNT_WID-1:0] idx_q;
    logic                   stot_q, rslt_vld_q, sign_q, sign_vld_q;

    logic                   in_sign;
    logic [MSG_WIDTH-1:0]   neg;
    logic [MAG_W-1:0]       in_abs;
    logic                   accept, emit;
    logic [MAG_W-1:0]       n_min0, n_min1;
    logic [COL_CNT_WID-1:0] n_idx0;
    logic                   n_sacc;

    // The most negative input has no positive counterpart; clamp it to max magnitude.
    assign in_sign = i_v2c[MSG_WIDTH-1];
    assign neg     = -i_v2c;
    assign in_abs  = !in_sign ? i_v2c[MAG_W-1:0]
                   : (neg[MSG_WIDTH-1] ? MAG_MAX : neg[MAG_W-1:0]);

    always_comb begin
        state_d   = state_q;
        min0_d    = min0_q;
        min1_d    = min1_q;
        idx0_d    = idx0_q;
        sacc_d    = sacc_q;
        seq_err_d = seq_err_q;
        accept    = 1'b0;
        emit      = 1'b0;
        n_min0    = min0_q;
        n_min1    = min1_q;
        n_idx0    = idx0_q;
        n_sacc    = sacc_q;
        if (i_v2c_vld) begin
            if (i_row_start) begin
                // A start while accumulating drops the partial row and restarts.
                accept = 1'b1;
                if (state_q == ACC) seq_err_d = 1'b1;
                n_min0 = in_abs;
                n_min1 = MAG_MAX;
                n_idx0 = i_col_cnt;
                n_sacc = in_sign;
            end else if (state_q == ACC) begin
                accept = 1'b1;
                n_sacc = sacc_q ^ in_sign;
                if (in_abs < min0_q) begin
                    n_min1 = min0_q;
                    n_min0 = in_abs;
                    n_idx0 = i_col_cnt;
                end else if (in_abs < min1_q) begin
                    n_min1 = in_abs;
                end
            end else begin
                seq_err_d = 1'b1;
            end
            if (accept) begin
                if (i_row_end) begin
                    emit    = 1'b1;
                    state_d = IDLE;
                    min0_d  = MAG_MAX;
                    min1_d  = MAG_MAX;
                    idx0_d  = '0;
                    sacc_d  = 1'b0;
                end else begin
                    state_d = ACC;
                    min0_d  = n_min0;
                    min1_d  = n_min1;
                    idx0_d  = n_idx0;
                    sacc_d  = n_sacc;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            min0_q     <= MAG_MAX;
            min1_q     <= MAG_MAX;
            idx0_q     <= '0;
            sacc_q     <= 1'b0;
            seq_err_q  <= 1'b0;
            abs0_q     <= '0;
            abs1_q     <= '0;
            idx_q      <= '0;
            stot_q     <= 1'b0;
            rslt_vld_q <= 1'b0;
            sign_q     <= 1'b0;
            sign_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            min0_q     <= min0_d;
            min1_q     <= min1_d;
            idx0_q     <= idx0_d;
            sacc_q     <= sacc_d;
            seq_err_q  <= seq_err_d;
            rslt_vld_q <= emit;
            sign_vld_q <= accept;
            if (accept) sign_q <= in_sign;
            if (emit) begin
                abs0_q <= n_min0;
                abs1_q <= n_min1;
                idx_q  <= n_idx0;
                stot_q <= n_sacc;
            end
        end
    end

    assign o_v2c_sign     = sign_q;
    assign o_v2c_sign_vld = sign_vld_q;
    assign o_v2c_abs_0    = abs0_q;
    assign o_v2c_abs_1    = abs1_q;
    assign o_idx_0        = idx_q;
    assign o_v2c_sign_tot = stot_q;
    assign o_rslt_vld     = rslt_vld_q;
    assign o_busy         = (state_q == ACC);
    assign o_seq_err      = seq_err_q;
endmodule

// File: tb/tb_cn_min_update.sv
// Directed bench for cn_min_update: expected row results and signs are queued
// as stimulus is driven and compared when the DUT presents them.
module tb_cn_min_update;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_v2c_vld = 1'b0;
    logic [5:0] i_v2c = '0;
    logic [6:0] i_col_cnt = '0;
    logic       i_row_start = 1'b0;
    logic       i_row_end = 1'b0;
    logic       o_v2c_sign, o_v2c_sign_vld;
    logic [4:0] o_v2c_abs_0, o_v2c_abs_1;
    logic [6:0] o_idx_0;
    logic       o_v2c_sign_tot, o_rslt_vld, o_busy, o_seq_err;

    typedef struct packed {
        logic [4:0] a0;
        logic [4:0] a1;
        logic [6:0] idx;
        logic       st;
    } res_t;

    res_t res_q[$];
    logic sgn_q[$];
    int   checks = 0;
    int   passes = 0;

    cn_min_update #(.MSG_WIDTH(6), .COL_CNT_WID(7)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_v2c_vld(i_v2c_vld), .i_v2c(i_v2c),
        .i_col_cnt(i_col_cnt), .i_row_start(i_row_start), .i_row_end(i_row_end),
        .o_v2c_sign(o_v2c_sign), .o_v2c_sign_vld(o_v2c_sign_vld),
        .o_v2c_abs_0(o_v2c_abs_0), .o_v2c_abs_1(o_v2c_abs_1), .o_idx_0(o_idx_0),
        .o_v2c_sign_tot(o_v2c_sign_tot), .o_rslt_vld(o_rslt_vld), .o_busy(o_busy),
        .o_seq_err(o_seq_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic exp_res(input int a0, input int a1, input int idx, input int st);
        res_t r;
        r.a0 = a0[4:0]; r.a1 = a1[4:0]; r.idx = idx[6:0]; r.st = st[0];
        res_q.push_back(r);
    endtask

    task automatic beat(input bit s, input bit e, input int v, input int col, input bit accepted);
        i_v2c_vld = 1'b1; i_row_start = s; i_row_end = e;
        i_v2c = v[5:0]; i_col_cnt = col[6:0];
        if (accepted) sgn_q.push_back(v < 0);
        @(posedge i_clk); #1;
        i_v2c_vld = 1'b0; i_row_start = 1'b0; i_row_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    // Output monitor: every pulse must match the oldest queued expectation.
    always @(negedge i_clk) begin
        if (o_rslt_vld) begin
            if (res_q.size() == 0) chk("unexpected_rslt_vld", 32'd1, 32'd0);
            else chk("row_result", {14'd0, o_v2c_abs_0, o_v2c_abs_1, o_idx_0, o_v2c_sign_tot},
                     {14'd0, res_q.pop_front()});
        end
        if (o_v2c_sign_vld) begin
            if (sgn_q.size() == 0) chk("unexpected_sign_vld", 32'd1, 32'd0);
            else chk("v2c_sign", {31'd0, o_v2c_sign}, {31'd0, sgn_q.pop_front()});
        end
    end

    initial begin
        idle(3);
        @(negedge i_clk);
        chk("reset_outputs", {14'd0, o_v2c_sign, o_v2c_sign_vld, o_v2c_abs_0, o_v2c_abs_1, o_idx_0,
            o_v2c_sign_tot, o_rslt_vld, o_busy, o_seq_err}, 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        idle(1);

        // Basic four-column row
        beat(1, 0, 7, 0, 1);
        beat(0, 0, -3, 1, 1);
        @(negedge i_clk); chk("busy_mid_row", {31'd0, o_busy}, 32'd1);
        beat(0, 0, 12, 2, 1);
        exp_res(3, 5, 1, 0);
        beat(0, 1, -5, 3, 1);
        @(negedge i_clk); chk("busy_after_end", {31'd0, o_busy}, 32'd0);
        idle(1);

        // Single-beat row with saturating most-negative input
        exp_res(31, 31, 9, 1);
        beat(1, 1, -32, 9, 1);
        idle(1);

        // Tie: equal magnitude goes to min1, earlier column keeps idx0
        beat(1, 0, 4, 2, 1);
        exp_res(4, 4, 2, 1);
        beat(0, 1, -4, 5, 1);
        idle(1);

        // Bubble with a stray end flag must not close the row
        beat(1, 0, 9, 0, 1);
        i_row_end = 1'b1;
        @(posedge i_clk); #1;
        i_row_end = 1'b0;
        @(negedge i_clk); chk("busy_in_bubble", {31'd0, o_busy}, 32'd1);
        beat(0, 0, 6, 1, 1);
        exp_res(2, 6, 2, 0);
        beat(0, 1, 2, 2, 1);
        idle(1);

        // Back-to-back rows with no dead cycle
        beat(1, 0, 1, 0, 1);
        exp_res(1, 10, 0, 0);
        beat(0, 1, 10, 1, 1);
        beat(1, 0, -7, 3, 1);
        exp_res(2, 7, 4, 0);
        beat(0, 1, -2, 4, 1);
        idle(1);

        // Full-scale magnitudes
        beat(1, 0, 31, 0, 1);
        beat(0, 0, -31, 1, 1);
        exp_res(31, 31, 0, 0);
        beat(0, 1, -32, 2, 1);
        idle(1);

        // Framing errors
        @(negedge i_clk); chk("seq_err_clean", {31'd0, o_seq_err}, 32'd0);
        beat(0, 0, 5, 7, 0);
        @(negedge i_clk); chk("seq_err_orphan", {31'd0, o_seq_err}, 32'd1);
        chk("orphan_not_busy", {31'd0, o_busy}, 32'd0);
        beat(1, 0, 3, 0, 1);
        beat(0, 0, 8, 1, 1);
        beat(1, 0, -6, 2, 1);
        exp_res(6, 9, 2, 1);
        beat(0, 1, 9, 3, 1);
        idle(1);
        @(negedge i_clk); chk("seq_err_sticky", {31'd0, o_seq_err}, 32'd1);

        // Reset mid-row discards the partial row
        beat(1, 0, 1, 0, 1);
        beat(0, 0, 2, 1, 1);
        i_rst_n = 1'b0;
        idle(2);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("busy_after_reset", {31'd0, o_busy}, 32'd0);
        chk("seq_err_after_reset", {31'd0, o_seq_err}, 32'd0);
        chk("rslt_vld_after_reset", {31'd0, o_rslt_vld}, 32'd0);
        beat(1, 0, 20, 5, 1);
        exp_res(15, 20, 6, 0);
        beat(0, 1, 15, 6, 1);
        idle(4);

        chk("results_drained", res_q.size(), 32'd0);
        chk("signs_drained", sgn_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
